// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the dual-port RAM initiator controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAPT  = 2'd2,
        RSP      = 2'd3
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int D_WIDTH_DEF = 16;
    localparam int A_WIDTH_DEF = 4;

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Burst read address register with modulo-2^A_WIDTH increment and remaining-beat counter.
// Loads on read accept, steps on each non-final response handshake; o_last flags the final beat.
module mem_burst_addr_gen #(
    parameter int A_WIDTH   = 4,
    parameter int LEN_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [A_WIDTH-1:0]   i_addr,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic                 i_step,
    output logic [A_WIDTH-1:0]   o_addr,
    output logic                 o_last
);

    logic [A_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0] r_beats_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_beats_left <= '0;
        end else if (i_load) begin
            r_addr       <= i_addr;
            r_beats_left <= i_len;
        end else if (i_step) begin
            // Natural overflow of the A_WIDTH-bit add gives the wrap to address 0.
            r_addr       <= r_addr + 1'b1;
            r_beats_left <= r_beats_left - 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_beats_left == '0);

endmodule

// File: rtl/mem_dp_ram.sv
// Dual-port RAM: one write port, one read port with a registered read (1-cycle latency).
// No reset on the array; contents survive controller resets.
module mem_dp_ram #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4
) (
    input  logic               clk_write,
    input  logic               clk_read,
    input  logic [A_WIDTH-1:0] address_write,
    input  logic [D_WIDTH-1:0] data_write,
    input  logic               write_enable,
    input  logic [A_WIDTH-1:0] address_read,
    output logic [D_WIDTH-1:0] data_read
);

    logic [D_WIDTH-1:0] r_mem [2**A_WIDTH];

    always_ff @(posedge clk_write) begin
        if (write_enable) begin
            r_mem[address_write] <= data_write;
        end
    end

    always_ff @(posedge clk_read) begin
        data_read <= r_mem[address_read];
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Initiator-side controller: valid/ready requests in, registered RAM port drive, read responses out.
// Latency: writes commit one edge after accept; read accept to rsp_valid is 2 cycles (3 per burst beat).
// Backpressure: req_ready only in IDLE; rsp_data/rsp_last hold while rsp_ready=0. Burst reads via MEM_CTRL_BURST_EN.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
`ifdef MEM_CTRL_BURST_EN
    parameter int LEN_WIDTH = 2,
`endif
    parameter int A_WIDTH   = A_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [A_WIDTH-1:0]   req_addr,
    input  logic [D_WIDTH-1:0]   req_wdata,
`ifdef MEM_CTRL_BURST_EN
    input  logic [LEN_WIDTH-1:0] req_len,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [D_WIDTH-1:0]   rsp_data,
    output logic                 rsp_last,
    output logic [A_WIDTH-1:0]   mem_address_write,
    output logic [D_WIDTH-1:0]   mem_data_write,
    output logic                 mem_write_enable,
    output logic [A_WIDTH-1:0]   mem_address_read,
    input  logic [D_WIDTH-1:0]   mem_data_read
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_rsp_hs;
    logic               w_last;
    logic [A_WIDTH-1:0] w_rd_addr;
    logic               r_we;
    logic [A_WIDTH-1:0] r_waddr;
    logic [D_WIDTH-1:0] r_wdata;
    logic [D_WIDTH-1:0] r_rsp_data;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RSP);
    assign w_rsp_hs  = rsp_valid & rsp_ready;
    assign w_wr_acc  = req_valid & req_ready & (req_we == OP_WRITE);
    assign w_rd_acc  = req_valid & req_ready & (req_we == OP_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_rd_acc) w_state_nxt = RD_ISSUE;
            RD_ISSUE: w_state_nxt = RD_CAPT;
            RD_CAPT:  w_state_nxt = RSP;
            RSP:      if (w_rsp_hs) w_state_nxt = w_last ? IDLE : RD_ISSUE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Write accepts only happen in IDLE, so the enable can never be high outside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_wr_acc;
            if (w_wr_acc) begin
                r_waddr <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
        end else if (r_state == RD_CAPT) begin
            r_rsp_data <= mem_data_read;
        end
    end

`ifdef MEM_CTRL_BURST_EN
    logic w_step;

    assign w_step = w_rsp_hs & ~w_last;

    mem_burst_addr_gen #(
        .A_WIDTH   (A_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_rd_acc),
        .i_addr (req_addr),
        .i_len  (req_len),
        .i_step (w_step),
        .o_addr (w_rd_addr),
        .o_last (w_last)
    );
`else
    logic [A_WIDTH-1:0] r_rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
        end else if (w_rd_acc) begin
            r_rd_addr <= req_addr;
        end
    end

    assign w_rd_addr = r_rd_addr;
    assign w_last    = 1'b1;
`endif

    assign mem_write_enable  = r_we;
    assign mem_address_write = r_waddr;
    assign mem_data_write    = r_wdata;
    assign mem_address_read  = w_rd_addr;
    assign rsp_data          = r_rsp_data;
    assign rsp_last          = rsp_valid & w_last;

endmodule
